// File: rtl/bram_dual_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bram_dual_arbiter_pkg
//   Shared types and the per-port round-robin arbitration function used by
//   bram_dual_arbiter. Each RAM port (write, read) runs one instance of the
//   same two-requester arbitration rule.
// ---------------------------------------------------------------------------
package bram_dual_arbiter_pkg;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

  typedef struct packed {
    logic gnt0;
    logic gnt1;
    logic contended;
  } port_gnt_t;

  // A lone requester always wins; when both request, the priority pointer
  // names the winner.
  function automatic port_gnt_t rr_arbitrate(input logic req0, input logic req1,
                                             input req_id_e pri);
    port_gnt_t g;
    g.contended = req0 & req1;
    g.gnt0      = req0 & (~req1 | (pri == REQ0));
    g.gnt1      = req1 & (~req0 | (pri == REQ1));
    return g;
  endfunction

endpackage

// File: rtl/bram_dual_arbiter_bram.sv
// ---------------------------------------------------------------------------
// bram_dual
//   Simple dual-port RAM: one write port, one read port, registered read
//   data with write-to-read forwarding on an address match.
// Ports:
//   clk_i    clock, rising edge
//   write_i  write enable
//   waddr_i  write address
//   data_i   write data
//   raddr_i  read address (sampled every edge)
//   data_o   registered read data
// ---------------------------------------------------------------------------
module bram_dual #(
  parameter int memSize_p   = 8,
  parameter int dataWidth_p = 16
) (
  input  logic                   clk_i,
  input  logic                   write_i,
  input  logic [memSize_p-1:0]   waddr_i,
  input  logic [dataWidth_p-1:0] data_i,
  input  logic [memSize_p-1:0]   raddr_i,
  output logic [dataWidth_p-1:0] data_o
);

  localparam int Depth = 2 ** memSize_p;

  logic [dataWidth_p-1:0] mem_q [Depth];
  logic [dataWidth_p-1:0] rdata_d;
  logic [dataWidth_p-1:0] rdata_q;

  // A write and read of the same word in one cycle returns the new word.
  always_comb begin
    rdata_d = mem_q[raddr_i];
    if (write_i && (waddr_i == raddr_i)) begin
      rdata_d = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (write_i) begin
      mem_q[waddr_i] <= data_i;
    end
    rdata_q <= rdata_d;
  end

  assign data_o = rdata_q;

endmodule

// File: rtl/bram_dual_arbiter.sv
// ---------------------------------------------------------------------------
// bram_dual_arbiter
//   Two-requester arbiter in front of one bram_dual. Writes go to the RAM
//   write port and reads to the RAM read port, each port arbitrated
//   round-robin on its own, so a read and a write from different requesters
//   complete in the same cycle. Read data returns one cycle after acceptance
//   on a shared bus, tagged by rvalid0_o / rvalid1_o.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   valid*_i, write*_i            command valid, 1 = write / 0 = read
//   addr*_i, wdata*_i             word address, write data
//   ready*_o                      command accepted this cycle (combinational)
//   rvalid*_o                     rdata_o belongs to requester 0 / 1
//   rdata_o                       shared read data
// ---------------------------------------------------------------------------
module bram_dual_arbiter
  import bram_dual_arbiter_pkg::*;
#(
  parameter int memSize_p   = 8,
  parameter int dataWidth_p = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   valid0_i,
  input  logic                   write0_i,
  input  logic [memSize_p-1:0]   addr0_i,
  input  logic [dataWidth_p-1:0] wdata0_i,
  input  logic                   valid1_i,
  input  logic                   write1_i,
  input  logic [memSize_p-1:0]   addr1_i,
  input  logic [dataWidth_p-1:0] wdata1_i,
  output logic                   ready0_o,
  output logic                   ready1_o,
  output logic                   rvalid0_o,
  output logic                   rvalid1_o,
  output logic [dataWidth_p-1:0] rdata_o
);

  req_id_e                wpri_q, wpri_d;
  req_id_e                rpri_q, rpri_d;
  logic                   rd_pend_q, rd_pend_d;
  req_id_e                rd_owner_q, rd_owner_d;
  logic [memSize_p-1:0]   raddr_q, raddr_d;

  port_gnt_t              wgnt;
  port_gnt_t              rgnt;
  logic                   ram_we;
  logic [memSize_p-1:0]   ram_waddr;
  logic [dataWidth_p-1:0] ram_wdata;

  always_comb begin
    wgnt = rr_arbitrate(valid0_i & write0_i, valid1_i & write1_i, wpri_q);
    rgnt = rr_arbitrate(valid0_i & ~write0_i, valid1_i & ~write1_i, rpri_q);

    // Nothing is accepted while reset is held, including a read that would
    // otherwise land on the edge where reset asserts.
    if (!rst_ni) begin
      wgnt = '0;
      rgnt = '0;
    end

    // On contention the pointer moves to the loser; otherwise it holds.
    wpri_d = wpri_q;
    if (wgnt.contended) begin
      wpri_d = wgnt.gnt0 ? REQ1 : REQ0;
    end
    rpri_d = rpri_q;
    if (rgnt.contended) begin
      rpri_d = rgnt.gnt0 ? REQ1 : REQ0;
    end

    ram_we    = wgnt.gnt0 | wgnt.gnt1;
    ram_waddr = wgnt.gnt1 ? addr1_i  : addr0_i;
    ram_wdata = wgnt.gnt1 ? wdata1_i : wdata0_i;

    // Holding the read address when idle keeps rdata_o stable.
    raddr_d = raddr_q;
    if (rgnt.gnt0) begin
      raddr_d = addr0_i;
    end else if (rgnt.gnt1) begin
      raddr_d = addr1_i;
    end

    rd_pend_d  = rgnt.gnt0 | rgnt.gnt1;
    rd_owner_d = rgnt.gnt1 ? REQ1 : REQ0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wpri_q     <= REQ0;
      rpri_q     <= REQ0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= REQ0;
    end else begin
      wpri_q     <= wpri_d;
      rpri_q     <= rpri_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  always_ff @(posedge clk_i) begin
    raddr_q <= raddr_d;
  end

  bram_dual #(
    .memSize_p   (memSize_p),
    .dataWidth_p (dataWidth_p)
  ) u_bram (
    .clk_i   (clk_i),
    .write_i (ram_we),
    .waddr_i (ram_waddr),
    .data_i  (ram_wdata),
    .raddr_i (raddr_d),
    .data_o  (rdata_o)
  );

  assign ready0_o  = wgnt.gnt0 | rgnt.gnt0;
  assign ready1_o  = wgnt.gnt1 | rgnt.gnt1;
  assign rvalid0_o = rd_pend_q & (rd_owner_q == REQ0);
  assign rvalid1_o = rd_pend_q & (rd_owner_q == REQ1);

endmodule

// File: tb/tb_bram_dual_arbiter.sv
module tb_bram_dual_arbiter;

  logic        clk;
  logic        rst_ni;
  logic        valid0, write0, valid1, write1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ready0, ready1, rvalid0, rvalid1;
  logic [15:0] rdata;

  int vectors;
  int miscompares;

  bram_dual_arbiter #(.memSize_p(8), .dataWidth_p(16)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .valid0_i  (valid0),
    .write0_i  (write0),
    .addr0_i   (addr0),
    .wdata0_i  (wdata0),
    .valid1_i  (valid1),
    .write1_i  (write1),
    .addr1_i   (addr1),
    .wdata1_i  (wdata1),
    .ready0_o  (ready0),
    .ready1_o  (ready1),
    .rvalid0_o (rvalid0),
    .rvalid1_o (rvalid1),
    .rdata_o   (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v0, input logic w0, input logic [7:0] a0, input logic [15:0] d0,
                       input logic v1, input logic w1, input logic [7:0] a1, input logic [15:0] d1);
    valid0 = v0; write0 = w0; addr0 = a0; wdata0 = d0;
    valid1 = v1; write1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
  endtask

  // Leaves the bench just after a falling edge with reset released.
  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    drive(1'b1, 1'b0, 8'h01, 16'h0, 1'b1, 1'b0, 8'h02, 16'h0);
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({ready0, ready1} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 00", {ready0, ready1});
    end
    vectors++;
    if ({rvalid0, rvalid1} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_rvalid: got %b want 00", {rvalid0, rvalid1});
    end
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    vectors++;
    if ({ready0, ready1} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_first_grant: got %b want 10", {ready0, ready1});
    end
    @(negedge clk);
    #1;
    vectors++;
    if ({ready0, ready1, rvalid0, rvalid1} !== 4'b0110) begin
      miscompares++;
      $display("FAIL reset_second_grant: got %b want 0110", {ready0, ready1, rvalid0, rvalid1});
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_cross_port();
    do_reset();
    drive(1'b1, 1'b1, 8'h10, 16'hBEEF, 1'b1, 1'b0, 8'h10, 16'h0);
    #1;
    vectors++;
    if ({ready0, ready1} !== 2'b11) begin
      miscompares++;
      $display("FAIL cross_ready: got %b want 11", {ready0, ready1});
    end
    @(negedge clk);
    idle();
    #1;
    vectors++;
    if ({rvalid0, rvalid1} !== 2'b01 || rdata !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL cross_rdata: got rv=%b data=%h want rv=01 data=beef", {rvalid0, rvalid1}, rdata);
    end
  endtask

  task automatic test_read_contention();
    logic [15:0] exp_d [2];
    exp_d[0] = 16'h1111;
    exp_d[1] = 16'h2222;
    do_reset();
    drive(1'b1, 1'b1, 8'h01, 16'h1111, 1'b0, 1'b0, 8'h00, 16'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b1, 8'h02, 16'h2222);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'h01, 16'h0, 1'b1, 1'b0, 8'h02, 16'h0);
      #1;
      vectors++;
      if (ready0 !== (i % 2 == 0) || ready1 !== (i % 2 == 1)) begin
        miscompares++;
        $display("FAIL rdcont_grant%0d: got %b want %b", i, {ready0, ready1},
                 (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      if (i > 0) begin
        vectors++;
        if (rvalid0 !== ((i - 1) % 2 == 0) || rvalid1 !== ((i - 1) % 2 == 1) ||
            rdata !== exp_d[(i - 1) % 2]) begin
          miscompares++;
          $display("FAIL rdcont_data%0d: got rv=%b data=%h want data=%h", i - 1,
                   {rvalid0, rvalid1}, rdata, exp_d[(i - 1) % 2]);
        end
      end
      @(negedge clk);
    end
    idle();
    #1;
    vectors++;
    if ({rvalid0, rvalid1} !== 2'b01 || rdata !== 16'h2222) begin
      miscompares++;
      $display("FAIL rdcont_data3: got rv=%b data=%h want rv=01 data=2222", {rvalid0, rvalid1}, rdata);
    end
  endtask

  task automatic test_write_contention();
    do_reset();
    drive(1'b1, 1'b1, 8'h20, 16'hAAAA, 1'b1, 1'b1, 8'h20, 16'h5555);
    #1;
    vectors++;
    if ({ready0, ready1} !== 2'b10) begin
      miscompares++;
      $display("FAIL wrcont_grant0: got %b want 10", {ready0, ready1});
    end
    @(negedge clk);
    #1;
    vectors++;
    if ({ready0, ready1} !== 2'b01) begin
      miscompares++;
      $display("FAIL wrcont_grant1: got %b want 01", {ready0, ready1});
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h20, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
    @(negedge clk);
    idle();
    #1;
    vectors++;
    if ({rvalid0, rvalid1} !== 2'b10 || rdata !== 16'h5555) begin
      miscompares++;
      $display("FAIL wrcont_final: got rv=%b data=%h want rv=10 data=5555", {rvalid0, rvalid1}, rdata);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b1, 8'h30, 16'h3333);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b0, 8'h30, 16'h0);
    #1;
    vectors++;
    if (ready1 !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_ready: got %b want 1", ready1);
    end
    @(posedge clk);
    #2;
    rst_ni = 1'b0;
    idle();
    #1;
    vectors++;
    if ({rvalid0, rvalid1} !== 2'b00) begin
      miscompares++;
      $display("FAIL rstmid_rvalid_in_reset: got %b want 00", {rvalid0, rvalid1});
    end
    #1;
    rst_ni = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if ({rvalid0, rvalid1} !== 2'b00) begin
      miscompares++;
      $display("FAIL rstmid_rvalid_after: got %b want 00", {rvalid0, rvalid1});
    end
    drive(1'b1, 1'b0, 8'h30, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
    @(negedge clk);
    idle();
    #1;
    vectors++;
    if ({rvalid0, rvalid1} !== 2'b10 || rdata !== 16'h3333) begin
      miscompares++;
      $display("FAIL rstmid_readback: got rv=%b data=%h want rv=10 data=3333", {rvalid0, rvalid1}, rdata);
    end
  endtask

  // Reference model: memory array, one priority index per port, and the
  // response expected from the previous cycle.
  task automatic test_random();
    logic [15:0] mdl [256];
    int          wpri, rpri;
    logic        pv [2], pw [2];
    logic [7:0]  pa [2];
    logic [15:0] pd [2];
    int          waits [2];
    logic        g [2];
    int          wreq [$], rreq [$];
    int          wwin, rwin;
    logic        exp_rv [2];
    logic [15:0] exp_rd;
    int          bad_grants, bad_resp, starved;

    do_reset();
    for (int a = 0; a < 256; a++) begin
      mdl[a] = 16'($urandom);
      drive(1'b1, 1'b1, 8'(a), mdl[a], 1'b0, 1'b0, 8'h00, 16'h0);
      @(negedge clk);
    end
    idle();
    wpri = 0; rpri = 0;
    exp_rv[0] = 1'b0; exp_rv[1] = 1'b0; exp_rd = '0;
    bad_grants = 0; bad_resp = 0; starved = 0;
    for (int r = 0; r < 2; r++) begin
      pv[r] = 1'b0; waits[r] = 0;
    end

    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pv[r]) begin
          pv[r] = ($urandom_range(0, 3) != 0);
          pw[r] = $urandom_range(0, 1) == 1;
          pa[r] = 8'($urandom);
          pd[r] = 16'($urandom);
          waits[r] = 0;
        end
      end
      drive(pv[0], pw[0], pa[0], pd[0], pv[1], pw[1], pa[1], pd[1]);
      #1;

      wreq.delete(); rreq.delete();
      for (int r = 0; r < 2; r++) begin
        g[r] = 1'b0;
        if (pv[r] && pw[r])  wreq.push_back(r);
        if (pv[r] && !pw[r]) rreq.push_back(r);
      end
      wwin = -1; rwin = -1;
      if (wreq.size() == 1) wwin = wreq[0];
      if (wreq.size() == 2) begin wwin = wpri; wpri = 1 - wwin; end
      if (rreq.size() == 1) rwin = rreq[0];
      if (rreq.size() == 2) begin rwin = rpri; rpri = 1 - rwin; end
      if (wwin >= 0) g[wwin] = 1'b1;
      if (rwin >= 0) g[rwin] = 1'b1;

      vectors++;
      if (ready0 !== g[0] || ready1 !== g[1]) begin
        miscompares++;
        if (bad_grants < 5)
          $display("FAIL rand_ready cyc%0d: got %b want %b", cyc, {ready0, ready1}, {g[0], g[1]});
        bad_grants++;
      end
      vectors++;
      if (rvalid0 !== exp_rv[0] || rvalid1 !== exp_rv[1] ||
          ((exp_rv[0] || exp_rv[1]) && rdata !== exp_rd)) begin
        miscompares++;
        if (bad_resp < 5)
          $display("FAIL rand_resp cyc%0d: got rv=%b data=%h want rv=%b data=%h", cyc,
                   {rvalid0, rvalid1}, rdata, {exp_rv[0], exp_rv[1]}, exp_rd);
        bad_resp++;
      end

      // Write lands before the read samples, so same-address reads see it.
      if (wwin >= 0) mdl[pa[wwin]] = pd[wwin];
      exp_rv[0] = (rwin == 0);
      exp_rv[1] = (rwin == 1);
      if (rwin >= 0) exp_rd = mdl[pa[rwin]];

      for (int r = 0; r < 2; r++) begin
        if (g[r]) begin
          pv[r] = 1'b0;
        end else if (pv[r]) begin
          waits[r]++;
          if (waits[r] > 2) begin
            vectors++;
            miscompares++;
            if (starved < 5)
              $display("FAIL rand_starve cyc%0d: req%0d waited %0d want <= 2", cyc, r, waits[r]);
            starved++;
          end
        end
      end
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_ni = 1'b0;
    idle();
    test_reset();
    test_cross_port();
    test_read_contention();
    test_write_contention();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
